// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: 2-bit counter states, BTB entry layout
// and the saturating counter helpers.
package bp_pkg;

  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

  localparam int BP_DBITS    = 32;
  localparam int BP_TAG_BITS = 16;

  // Entry layout at the default address/tag widths, for code outside the predictor.
  typedef struct packed {
    logic                   valid;
    logic [BP_TAG_BITS-1:0] tag;
    logic [BP_DBITS-1:0]    target;
  } btb_entry_t;

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return (c == ST) ? ST : c + 2'd1;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return (c == SNT) ? SNT : c - 2'd1;
  endfunction

  function automatic logic ctr_taken(input logic [1:0] c);
    return c >= WT;
  endfunction

endpackage

// File: rtl/bp_ras.sv
// Circular return address stack: push overwrites the oldest entry when full,
// simultaneous push and pop replaces the top in place.
module bp_ras #(
  parameter int DEPTH = 4,
  parameter int DBITS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [DBITS-1:0] push_data_i,
  output logic [DBITS-1:0] top_o,
  output logic             empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DBITS-1:0] r_stack [DEPTH];
  logic [PW-1:0]    r_top;
  logic [CW-1:0]    r_count;
  logic             w_pop;
  logic [PW-1:0]    w_top_inc;

  assign empty_o   = (r_count == '0);
  assign w_pop     = pop_i & ~empty_o;
  assign w_top_inc = r_top + PW'(1);
  assign top_o     = r_stack[r_top];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_top   <= '0;
      r_count <= '0;
    end else if (push_i && !w_pop) begin
      r_top <= w_top_inc;
      if (r_count != CW'(DEPTH)) begin
        r_count <= r_count + CW'(1);
      end
    end else if (w_pop && !push_i) begin
      r_top   <= r_top - PW'(1);
      r_count <= r_count - CW'(1);
    end
  end

  // Storage needs no reset: the count alone decides whether the top is meaningful.
  always_ff @(posedge clk) begin
    if (push_i && w_pop) begin
      r_stack[r_top] <= push_data_i;
    end else if (push_i) begin
      r_stack[w_top_inc] <= push_data_i;
    end
  end

endmodule

// File: rtl/gshare_bp.sv
// gshare predictor: PC xor global history selects a 2-bit counter, a tagged BTB gives targets.
// Defining GSHARE_RAS_EN adds a return address stack that overrides the prediction for returns.
module gshare_bp
  import bp_pkg::*;
#(
  parameter int         DBITS        = 32,
  parameter int         GHR_BITS     = 8,
  parameter int         BTB_IDX_BITS = 4,
  parameter int         BTB_TAG_BITS = 16,
  parameter int         RAS_DEPTH    = 4,
  parameter logic [1:0] CTR_INIT     = WNT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pred_valid_i,
  input  logic [DBITS-1:0]    pred_pc_i,
  input  logic                pred_is_branch_i,
  input  logic                pred_is_call_i,
  input  logic                pred_is_ret_i,
  output logic                pred_taken_o,
  output logic [DBITS-1:0]    pred_target_o,
  output logic [GHR_BITS-1:0] pred_pht_idx_o,
  output logic                pred_btb_hit_o,
  input  logic                upd_valid_i,
  input  logic                upd_taken_i,
  input  logic [GHR_BITS-1:0] upd_pht_idx_i,
  input  logic [DBITS-1:0]    upd_pc_i,
  input  logic [DBITS-1:0]    upd_target_i
);

  localparam int PHT_N  = 1 << GHR_BITS;
  localparam int BTB_N  = 1 << BTB_IDX_BITS;
  localparam int TAG_LO = BTB_IDX_BITS + 2;
  localparam int TAG_HI = BTB_TAG_BITS + BTB_IDX_BITS + 1;

  typedef struct packed {
    logic                    valid;
    logic [BTB_TAG_BITS-1:0] tag;
    logic [DBITS-1:0]        target;
  } btb_row_t;

  logic [1:0]              r_pht [PHT_N];
  logic [GHR_BITS-1:0]     r_bhr;
  logic [BTB_N-1:0]        r_btb_valid;
  logic [BTB_TAG_BITS-1:0] r_btb_tag [BTB_N];
  logic [DBITS-1:0]        r_btb_tgt [BTB_N];

  logic [GHR_BITS-1:0]     w_pht_idx;
  logic [BTB_IDX_BITS-1:0] w_btb_idx;
  logic [BTB_TAG_BITS-1:0] w_tag;
  btb_row_t                w_rd;
  logic                    w_hit;
  logic                    w_dir_taken;
  logic [DBITS-1:0]        w_pc_plus4;
  logic [BTB_IDX_BITS-1:0] w_upd_btb_idx;
  logic [BTB_TAG_BITS-1:0] w_upd_tag;
  logic                    w_btb_wr;

  assign w_pht_idx     = pred_pc_i[GHR_BITS+1:2] ^ r_bhr;
  assign w_btb_idx     = pred_pc_i[BTB_IDX_BITS+1:2];
  assign w_tag         = pred_pc_i[TAG_HI:TAG_LO];
  assign w_upd_btb_idx = upd_pc_i[BTB_IDX_BITS+1:2];
  assign w_upd_tag     = upd_pc_i[TAG_HI:TAG_LO];
  assign w_btb_wr      = upd_valid_i & upd_taken_i;
  assign w_pc_plus4    = pred_pc_i + DBITS'(4);

  assign w_rd = '{valid:  r_btb_valid[w_btb_idx],
                  tag:    r_btb_tag[w_btb_idx],
                  target: r_btb_tgt[w_btb_idx]};

  assign w_hit       = w_rd.valid && (w_rd.tag == w_tag);
  assign w_dir_taken = pred_valid_i & pred_is_branch_i & w_hit & ctr_taken(r_pht[w_pht_idx]);

  assign pred_pht_idx_o = w_pht_idx;
  assign pred_btb_hit_o = w_hit;

  // Training is non-speculative: history shifts only on resolved branches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < PHT_N; i++) begin
        r_pht[i] <= CTR_INIT;
      end
      r_bhr <= '0;
    end else if (upd_valid_i) begin
      r_pht[upd_pht_idx_i] <= upd_taken_i ? ctr_inc(r_pht[upd_pht_idx_i])
                                          : ctr_dec(r_pht[upd_pht_idx_i]);
      r_bhr <= {r_bhr[GHR_BITS-2:0], upd_taken_i};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_btb_valid <= '0;
    end else if (w_btb_wr) begin
      r_btb_valid[w_upd_btb_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_btb_wr) begin
      r_btb_tag[w_upd_btb_idx] <= w_upd_tag;
      r_btb_tgt[w_upd_btb_idx] <= upd_target_i;
    end
  end

`ifdef GSHARE_RAS_EN
  logic             w_ras_empty;
  logic             w_ras_hit;
  logic [DBITS-1:0] w_ras_top;
  logic             w_unused;

  assign w_ras_hit = pred_valid_i & pred_is_ret_i & ~w_ras_empty;
  assign w_unused  = ^{upd_pc_i[DBITS-1:TAG_HI+1], upd_pc_i[1:0]};

  bp_ras #(
    .DEPTH (RAS_DEPTH),
    .DBITS (DBITS)
  ) u_ras (
    .clk         (clk),
    .reset       (reset),
    .push_i      (pred_valid_i & pred_is_call_i),
    .pop_i       (w_ras_hit),
    .push_data_i (w_pc_plus4),
    .top_o       (w_ras_top),
    .empty_o     (w_ras_empty)
  );

  always_comb begin
    pred_taken_o  = w_dir_taken;
    pred_target_o = w_dir_taken ? w_rd.target : w_pc_plus4;
    if (w_ras_hit) begin
      pred_taken_o  = 1'b1;
      pred_target_o = w_ras_top;
    end
  end
`else
  logic w_unused;

  assign w_unused = ^{pred_is_call_i, pred_is_ret_i,
                      upd_pc_i[DBITS-1:TAG_HI+1], upd_pc_i[1:0]};

  always_comb begin
    pred_taken_o  = w_dir_taken;
    pred_target_o = w_dir_taken ? w_rd.target : w_pc_plus4;
  end
`endif

endmodule
